// File: rtl/uart_defs_pkg.sv
// UART shared definitions: state encoding, frame width
// and the clocks-per-bit helper used by tx and rx sides.
package uart_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uartState_t;

  localparam int DATA_BITS = 8;

  function automatic int clksPerBit(
    input int clockRate,
    input int baudRate
  );
    return clockRate / baudRate;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: one-cycle tick every CLKS_PER_BIT
// cycles, restartable so the bit phase aligns to accept.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic tick
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // count 0..CLKS_PER_BIT-1, wrap, restart on clear
  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart8_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first,
// one stop bit; all outputs registered.
module uart8_tx
  import uart_defs::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in,
  output logic       tx,
  output logic       txBusy,
  output logic       txDone
);

  localparam int CLKS_PER_BIT =
    clksPerBit(CLOCK_RATE, BAUD_RATE);
  localparam logic [2:0] LAST_BIT =
    3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : gBadRate
    $error("uart8_tx: CLKS_PER_BIT must be >= 2");
  end

  uartState_t state;
  uartState_t nextState;
  logic [7:0] shreg;
  logic [7:0] shregNext;
  logic [2:0] bitIdx;
  logic [2:0] bitIdxNext;
  logic       accept;
  logic       tick;
  logic       txNext;
  logic       busyNext;
  logic       doneNext;

  assign accept = (state == IDLE) && txEn && txStart;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uTick (
    .clk  (clk),
    .rstn (rstn),
    .clear(accept),
    .tick (tick)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // next-state: each non-idle state lasts whole bit periods
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (accept) nextState = START;
      START: if (tick) nextState = DATA;
      DATA:
        if (tick && bitIdx == LAST_BIT)
          nextState = STOP;
      STOP:  if (tick) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // shifter: load on accept, shift between data bits
  always_comb begin
    shregNext  = shreg;
    bitIdxNext = bitIdx;
    if (accept) begin
      shregNext  = in;
      bitIdxNext = '0;
    end else if (state == DATA && tick &&
                 bitIdx != LAST_BIT) begin
      shregNext  = {1'b0, shreg[7:1]};
      bitIdxNext = bitIdx + 3'd1;
    end
  end

  // shift register and bit index
  always_ff @(posedge clk) begin
    if (!rstn) begin
      shreg  <= '0;
      bitIdx <= '0;
    end else begin
      shreg  <= shregNext;
      bitIdx <= bitIdxNext;
    end
  end

  // output decode from the state being entered
  always_comb begin
    txNext   = 1'b1;
    busyNext = (nextState != IDLE);
    doneNext = (state == STOP) && tick;
    unique case (nextState)
      START:   txNext = 1'b0;
      DATA:    txNext = shregNext[0];
      default: txNext = 1'b1;
    endcase
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx     <= 1'b1;
      txBusy <= 1'b0;
      txDone <= 1'b0;
    end else begin
      tx     <= txNext;
      txBusy <= busyNext;
      txDone <= doneNext;
    end
  end

endmodule
